// File: rtl/decode_issue_queue.sv
// In-order decode-and-issue queue: decodes MIPS words into a unit class and operand count at
// enqueue, then issues the head entry to the ALU, LSU or MULT port with valid/ready handshakes.
module decode_issue_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned CNT_W    = 16,
   parameter bit          PASS_NOP = 1'b0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic                       flush,
   output logic [2:0]                 iss_valid,
   input  logic [2:0]                 iss_ready,
   output logic [31:0]                iss_instr,
   output logic [TAG_W-1:0]           iss_tag,
   output logic [1:0]                 iss_numop,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic [CNT_W-1:0]           stall_cycles
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {ClsNone = 2'd0, ClsAlu = 2'd1, ClsLsu = 2'd2, ClsMult = 2'd3} cls_e;

   logic [31:0]      instr_q [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   cls_e             cls_q   [DEPTH];
   logic [1:0]       numop_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   cls_e       dec_cls;
   logic [1:0] dec_numop;
   cls_e       head_cls;
   logic       drop;
   logic       push;
   logic       pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      dec_cls   = ClsNone;
      dec_numop = 2'd0;
      case (in_instr[31:26])
         6'h00: begin
            case (in_instr[5:0])
               6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27: begin
                  dec_cls   = ClsAlu;
                  dec_numop = 2'd2;
               end
               6'h08: begin
                  dec_cls   = ClsAlu;
                  dec_numop = 2'd1;
               end
               6'h18: begin
                  dec_cls   = ClsMult;
                  dec_numop = 2'd2;
               end
               default: ;
            endcase
         end
         6'h04, 6'h05: begin
            dec_cls   = ClsAlu;
            dec_numop = 2'd2;
         end
         6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
            dec_cls   = ClsAlu;
            dec_numop = 2'd1;
         end
         6'h23: begin
            dec_cls   = ClsLsu;
            dec_numop = 2'd1;
         end
         6'h2B: begin
            dec_cls   = ClsLsu;
            dec_numop = 2'd2;
         end
         default: ;
      endcase
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == OCC_W'(DEPTH));
   assign in_ready = !full;
   assign count    = count_q;
   assign stall_cycles = stall_q;

   assign head_cls  = cls_q[rd_ptr_q];
   assign iss_instr = instr_q[rd_ptr_q];
   assign iss_tag   = tag_q[rd_ptr_q];
   assign iss_numop = numop_q[rd_ptr_q];

   // Class-0 heads are silently discarded unless they are passed through as ALU no-ops.
   assign drop = !empty && (head_cls == ClsNone) && !PASS_NOP;

   always_comb begin
      iss_valid = 3'b000;
      if (!empty && !drop) begin
         case (head_cls)
            ClsLsu:  iss_valid = 3'b010;
            ClsMult: iss_valid = 3'b100;
            default: iss_valid = 3'b001;
         endcase
      end
   end

   assign push = in_valid && in_ready && !flush;
   assign pop  = !flush && (drop || (|(iss_valid & iss_ready)));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      count_d = count_q + OCC_W'(1);
         else if (pop && !push) count_d = count_q - OCC_W'(1);
      end
   end

   // Flush neither counts as a stall nor clears the counter.
   always_comb begin
      stall_d = stall_q;
      if (!empty && !flush && !pop && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   // Entry storage carries no reset; only the pointers and count qualify it.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_q[wr_ptr_q] <= in_instr;
         tag_q[wr_ptr_q]   <= in_tag;
         cls_q[wr_ptr_q]   <= dec_cls;
         numop_q[wr_ptr_q] <= dec_numop;
      end
   end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: a vector table for the main flows plus hand sequences
// for stall, flush, asynchronous reset and a PASS_NOP=1 / CNT_W=3 / DEPTH=3 instance.
module tb_decode_issue_queue;

   localparam logic [31:0] I_ADD  = 32'h00851020;
   localparam logic [31:0] I_LW   = 32'h8C820004;
   localparam logic [31:0] I_SW   = 32'hAC820004;
   localparam logic [31:0] I_MULT = 32'h00850018;
   localparam logic [31:0] I_ADDI = 32'h20820005;
   localparam logic [31:0] I_J    = 32'h08000010;
   localparam logic [31:0] I_OR   = 32'h00851025;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, flush, empty, full;
   logic [31:0] in_instr, iss_instr;
   logic [3:0]  in_tag, iss_tag;
   logic [2:0]  iss_valid, iss_ready, count;
   logic [1:0]  iss_numop;
   logic [15:0] stall_cycles;

   logic        in2_valid, in2_ready, flush2, empty2, full2;
   logic [31:0] in2_instr, iss2_instr;
   logic [3:0]  in2_tag, iss2_tag;
   logic [2:0]  iss2_valid, iss2_ready, stall2;
   logic [1:0]  iss2_numop, count2;

   int checks = 0;
   int errors = 0;

   decode_issue_queue #(.DEPTH(4), .TAG_W(4), .CNT_W(16), .PASS_NOP(1'b0)) u_dut (
      .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .iss_valid(iss_valid),
      .iss_ready(iss_ready), .iss_instr(iss_instr), .iss_tag(iss_tag), .iss_numop(iss_numop),
      .count(count), .empty(empty), .full(full), .stall_cycles(stall_cycles)
   );

   decode_issue_queue #(.DEPTH(3), .TAG_W(4), .CNT_W(3), .PASS_NOP(1'b1)) u_dut2 (
      .clock(clk), .reset(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
      .in_instr(in2_instr), .in_tag(in2_tag), .flush(flush2), .iss_valid(iss2_valid),
      .iss_ready(iss2_ready), .iss_instr(iss2_instr), .iss_tag(iss2_tag),
      .iss_numop(iss2_numop), .count(count2), .empty(empty2), .full(full2),
      .stall_cycles(stall2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [3:0]  tag;
      logic [2:0]  rdy;
      logic        fl;
      logic [2:0]  e_val;
      logic [1:0]  e_nop;
      logic [3:0]  e_tag;
      logic [2:0]  e_cnt;
      logic        e_full;
      logic [15:0] e_stall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic [3:0] tag,
                               input logic [2:0] rdy, input logic fl, input logic [2:0] ev,
                               input logic [1:0] en, input logic [3:0] et,
                               input logic [2:0] ec, input logic ef, input logic [15:0] es);
      vec_t r;
      r.v = v; r.instr = instr; r.tag = tag; r.rdy = rdy; r.fl = fl;
      r.e_val = ev; r.e_nop = en; r.e_tag = et; r.e_cnt = ec; r.e_full = ef; r.e_stall = es;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic v, input logic [31:0] instr, input logic [3:0] tag,
                        input logic [2:0] rdy, input logic fl);
      @(negedge clk);
      in_valid = v; in_instr = instr; in_tag = tag; iss_ready = rdy; flush = fl;
      #1;
   endtask

   task automatic drive2(input logic v, input logic [31:0] instr, input logic [3:0] tag,
                         input logic [2:0] rdy);
      @(negedge clk);
      in2_valid = v; in2_instr = instr; in2_tag = tag; iss2_ready = rdy;
      #1;
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      drive(t.v, t.instr, t.tag, t.rdy, t.fl);
      chk($sformatf("v%0d iss_valid", idx), 32'(iss_valid), 32'(t.e_val));
      if (t.e_val != 3'b000) begin
         chk($sformatf("v%0d iss_numop", idx), 32'(iss_numop), 32'(t.e_nop));
         chk($sformatf("v%0d iss_tag", idx), 32'(iss_tag), 32'(t.e_tag));
      end
      chk($sformatf("v%0d count", idx), 32'(count), 32'(t.e_cnt));
      chk($sformatf("v%0d full", idx), 32'(full), 32'(t.e_full));
      chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(!t.e_full));
      chk($sformatf("v%0d empty", idx), 32'(empty), 32'(t.e_cnt == 3'd0));
      chk($sformatf("v%0d stall", idx), 32'(stall_cycles), 32'(t.e_stall));
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_instr = '0; in_tag = '0; iss_ready = '0; flush = 1'b0;
      in2_valid = 1'b0; in2_instr = '0; in2_tag = '0; iss2_ready = '0; flush2 = 1'b0;

      // Single ADD, then the 4-entry fill/drain with an ignored fifth push
      vecs.push_back(mk(0, 0,      0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, I_ADD,  1, 3'b001, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0,      0, 3'b001, 0, 3'b001, 2, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0,      0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, I_LW,   2, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, I_SW,   3, 3'b000, 0, 3'b010, 1, 2, 1, 0, 0));
      vecs.push_back(mk(1, I_MULT, 4, 3'b000, 0, 3'b010, 1, 2, 2, 0, 1));
      vecs.push_back(mk(1, I_ADDI, 5, 3'b000, 0, 3'b010, 1, 2, 3, 0, 2));
      vecs.push_back(mk(1, I_ADD,  6, 3'b000, 0, 3'b010, 1, 2, 4, 1, 3));
      vecs.push_back(mk(0, 0,      0, 3'b111, 0, 3'b010, 1, 2, 4, 1, 4));
      vecs.push_back(mk(0, 0,      0, 3'b111, 0, 3'b010, 2, 3, 3, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b111, 0, 3'b100, 2, 4, 2, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b111, 0, 3'b001, 1, 5, 1, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b111, 0, 3'b000, 0, 0, 0, 0, 4));
      // Streaming ten tags through with simultaneous push and pop
      vecs.push_back(mk(1, I_ADD,  0, 3'b001, 0, 3'b000, 0, 0, 0, 0, 4));
      for (int k = 1; k < 10; k++)
         vecs.push_back(mk(1, I_ADD, 4'(k), 3'b001, 0, 3'b001, 2, 4'(k - 1), 1, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b001, 0, 3'b001, 2, 9, 1, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b001, 0, 3'b000, 0, 0, 0, 0, 4));
      // J is dropped at the head, OR follows on the ALU port
      vecs.push_back(mk(1, I_J,   10, 3'b001, 0, 3'b000, 0, 0, 0, 0, 4));
      vecs.push_back(mk(1, I_OR,  11, 3'b001, 0, 3'b000, 0, 0, 1, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b001, 0, 3'b001, 2, 11, 1, 0, 4));
      vecs.push_back(mk(0, 0,      0, 3'b001, 0, 3'b000, 0, 0, 0, 0, 4));

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Asynchronous reset with two entries queued
      drive(1, I_ADD, 1, 3'b000, 0);
      drive(1, I_ADD, 2, 3'b000, 0);
      drive(0, 0, 0, 3'b000, 0);
      chk("pre-reset count", 32'(count), 32'd2);
      chk("pre-reset stall", 32'(stall_cycles), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst count", 32'(count), 32'd0);
      chk("rst empty", 32'(empty), 32'd1);
      chk("rst full", 32'(full), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst iss_valid", 32'(iss_valid), 32'd0);
      chk("rst stall", 32'(stall_cycles), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // MULT head stalled with only the ALU ready: younger ADD must stay blocked
      drive(1, I_MULT, 12, 3'b001, 0);
      drive(1, I_ADD, 13, 3'b001, 0);
      chk("stall head valid", 32'(iss_valid), 32'b100);
      chk("stall head tag", 32'(iss_tag), 32'd12);
      repeat (4) drive(0, 0, 0, 3'b001, 0);
      drive(0, 0, 0, 3'b001, 0);
      chk("stall count5", 32'(stall_cycles), 32'd5);
      chk("stall blocked valid", 32'(iss_valid), 32'b100);
      chk("stall occupancy", 32'(count), 32'd2);
      drive(0, 0, 0, 3'b100, 0);
      chk("stall release valid", 32'(iss_valid), 32'b100);
      chk("stall held", 32'(stall_cycles), 32'd6);
      drive(0, 0, 0, 3'b001, 0);
      chk("after mult valid", 32'(iss_valid), 32'b001);
      chk("after mult tag", 32'(iss_tag), 32'd13);
      drive(0, 0, 0, 3'b000, 0);
      chk("after mult count", 32'(count), 32'd0);

      // Flush with three entries, a pending push and a pending LSU transfer
      drive(1, I_LW, 1, 3'b000, 0);
      drive(1, I_SW, 2, 3'b000, 0);
      drive(1, I_ADD, 3, 3'b000, 0);
      drive(1, I_ADD, 4, 3'b010, 1);
      chk("pre-flush count", 32'(count), 32'd3);
      chk("pre-flush valid", 32'(iss_valid), 32'b010);
      chk("pre-flush stall", 32'(stall_cycles), 32'd8);
      drive(0, 0, 0, 3'b000, 0);
      chk("flush count", 32'(count), 32'd0);
      chk("flush empty", 32'(empty), 32'd1);
      chk("flush iss_valid", 32'(iss_valid), 32'd0);
      chk("flush stall kept", 32'(stall_cycles), 32'd8);
      drive(1, I_ADD, 5, 3'b000, 0);
      drive(0, 0, 0, 3'b001, 0);
      chk("post-flush valid", 32'(iss_valid), 32'b001);
      chk("post-flush tag", 32'(iss_tag), 32'd5);

      // PASS_NOP=1, DEPTH=3, CNT_W=3 instance
      drive2(1, I_J, 7, 3'b001);
      drive2(1, I_MULT, 1, 3'b001);
      chk("nop valid", 32'(iss2_valid), 32'b001);
      chk("nop numop", 32'(iss2_numop), 32'd0);
      chk("nop tag", 32'(iss2_tag), 32'd7);
      drive2(1, I_ADD, 2, 3'b000);
      chk("d2 mult valid", 32'(iss2_valid), 32'b100);
      drive2(1, I_ADD, 3, 3'b000);
      repeat (10) drive2(0, 0, 0, 3'b000);
      drive2(1, I_ADD, 9, 3'b000);
      chk("d2 count full", 32'(count2), 32'd3);
      chk("d2 full", 32'(full2), 32'd1);
      chk("d2 in_ready", 32'(in2_ready), 32'd0);
      chk("d2 stall sat", 32'(stall2), 32'd7);
      drive2(0, 0, 0, 3'b111);
      chk("d2 drain0 valid", 32'(iss2_valid), 32'b100);
      chk("d2 drain0 tag", 32'(iss2_tag), 32'd1);
      drive2(0, 0, 0, 3'b111);
      chk("d2 drain1 tag", 32'(iss2_tag), 32'd2);
      chk("d2 drain1 numop", 32'(iss2_numop), 32'd2);
      drive2(0, 0, 0, 3'b111);
      chk("d2 drain2 valid", 32'(iss2_valid), 32'b001);
      chk("d2 drain2 tag", 32'(iss2_tag), 32'd3);
      drive2(0, 0, 0, 3'b111);
      chk("d2 empty", 32'(empty2), 32'd1);
      chk("d2 stall kept", 32'(stall2), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- In-order decode-and-issue buffer placed between fetch and the functional units.
- Decodes each incoming MIPS instruction into a functional-unit class and an operand count, then stores it in a parametrised circular queue.
- Issues the head entry to exactly one of three unit ports (ALU, LSU, MULT) using a per-port valid/ready handshake.
- Provides flush, occupancy reporting and a saturating head-stall counter.

Parameters:
DEPTH, 4, queue entries; must be >=2 (not required to be a power of 2).
TAG_W, 4, width of the instruction tag carried alongside each entry.
CNT_W, 16, width of the stall counter.
PASS_NOP, 0, 1: class-0 entries issue on the ALU port with numop=0; 0: class-0 entries are dropped at the head without issuing.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  queue accepts an instruction; equals !full (no same-cycle pop bypass)
in_instr  in  32  instruction word
in_tag  in  TAG_W  tag stored with the instruction
flush  in  1  synchronous queue clear
iss_valid  out  3  one-hot issue valid; bit0 ALU, bit1 LSU, bit2 MULT
iss_ready  in  3  per-unit ready, same bit order as iss_valid
iss_instr  out  32  head instruction word
iss_tag  out  TAG_W  head tag
iss_numop  out  2  head operand count (0, 1 or 2)
count  out  $clog2(DEPTH+1)  current occupancy
empty  out  1  count==0
full  out  1  count==DEPTH
stall_cycles  out  CNT_W  saturating head-stall counter

Behaviour:
- Decode is applied at enqueue to op = instr[31:26] and fn = instr[5:0]. Class and numop are stored with each entry.
  - op 00: fn 04/06/07/20-27 -> ALU, numop 2; fn 08 (JR) -> ALU, numop 1; fn 18 (MULT) -> MULT, numop 2; any other fn -> class 0, numop 0.
  - op 02 (J) -> class 0, numop 0.
  - op 04/05 -> ALU, numop 2.
  - op 06/07/08/09/0C/0D/0E -> ALU, numop 1.
  - op 23 (LW) -> LSU, numop 1.
  - op 2B (SW) -> LSU, numop 2.
  - any other op -> class 0, numop 0.
- Push: in_valid && in_ready && !flush. The entry is written at wr_ptr; wr_ptr increments and wraps from DEPTH-1 to 0.
- Issue outputs are combinational from the registered head entry.
  - When empty, or when the head is class 0 with PASS_NOP=0: iss_valid = 000.
  - Otherwise exactly one iss_valid bit is set, selected by class (class 0 maps to the ALU bit when PASS_NOP=1).
  - iss_instr, iss_tag and iss_numop are don't-care while iss_valid==000.
- Pop occurs on a transfer (iss_valid[i] && iss_ready[i]), or unconditionally when the head is class 0 and PASS_NOP=0. At most one pop per cycle. rd_ptr wraps as wr_ptr does.
- Simultaneous push and pop: count is unchanged and both pointers advance. Because in_ready=!full, a full queue never pushes, even in a cycle where it pops.
- Flush, when asserted, takes priority over push and pop in that cycle:
  - Next state: count=0 and pointers=0.
  - The in-flight handshake that cycle is not considered accepted by either side.
- Stall counter:
  - Increments each cycle in which the queue is non-empty, flush=0, and no pop occurs.
  - Saturates at all-ones.
  - Cleared only by reset; unaffected by flush.
- Reset (asynchronous, any time, including mid-handshake):
  - count=0, pointers=0, empty=1, full=0, in_ready=1, iss_valid=000, stall_cycles=0.
  - Entry storage is not reset.
- Issue order is strictly program order. A stalled head blocks younger entries, even when those target ready units.

Test Plan:
- Reset, then push ADD (0x00851020, tag 1) with iss_ready=001 -> next cycle iss_valid=001, iss_numop=2, iss_tag=1; one cycle later count=0, empty=1.
- DEPTH=4: push LW 0x8C820004, SW 0xAC820004, MULT 0x00850018, ADDI 0x20820005 with iss_ready=000 -> full=1, in_ready=0, and a fifth push is ignored. Then raise iss_ready=111 -> issue order LSU(numop1), LSU(numop2), MULT, ALU(numop1) on consecutive cycles.
- Continuous push plus pop streaming 10 instructions through DEPTH=4 -> pointers wrap, count stays at 1, all tags are issued in order with no loss.
- PASS_NOP=0: push J 0x08000010 then OR 0x00851025 -> the J is dropped with iss_valid staying 000 for that cycle, then OR issues on ALU. With PASS_NOP=1 the J issues on ALU with numop=0.
- Head is MULT with iss_ready[2]=0 for 5 cycles -> stall_cycles=5. With CNT_W=3 and a 10-cycle stall -> stall_cycles stays at 7.
- Assert flush with 3 entries queued while in_valid=1 and a transfer is pending -> next cycle count=0, no push, and stall_cycles is retained. Assert reset mid-queue -> all outputs immediately take their reset values.
